// File: rtl/ifu_fetch_pkg.sv
// Shared constants, state encodings and helpers for the instruction fetch unit.
// No logic of its own; imported by every ifu_fetch file.
// Holds the reset PC default, the nop encoding and the 3-bit FSM state encodings.
package ifu_fetch_pkg;

    localparam int          IFU_XLEN     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4,
        ST_ERR  = 3'd5
    } ifu_state_e;

    // Redirect targets may be unaligned; fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_reg.sv
// Generic register with a synchronous active-low reset to a parameterised value.
// Latency: one cycle from d to q.
// Backpressure: none; it loads d on every clock edge.
module ifu_fetch_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Plain register; reset wins over the next value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one word fetch at a time and hands word+PC to decode.
// Latency: 3 cycles per instruction with a zero-wait memory (REQ, WAIT, HOLD).
// Backpressure: decode stall holds the word in HOLD with no new request; redirects drop stale fetches.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          XLEN     = IFU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_err
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] redir_pc;

    ifu_fetch_reg #(
        .WIDTH     (32),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pc_d),
        .q     (pc_q)
    );

    // Next-state and datapath decisions; a redirect always takes priority over normal progress.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        fetch_err_d = fetch_err_q;
        redir_pc    = align_pc(redirect_pc);
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                // Once accepted with a redirect, the response is still owed and must be drained.
                if (mem_req_ready) begin
                    if (redirect_valid) begin
                        pc_d    = redir_pc;
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (redirect_valid) begin
                    pc_d = redir_pc;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = mem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        fetch_err_d = 1'b1;
                        state_d     = ST_ERR;
                    end else begin
                        inst_d    = mem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (mem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_ERR: begin
                if (redirect_valid) begin
                    fetch_err_d = 1'b0;
                    pc_d        = redir_pc;
                    state_d     = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured word and error flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inst_q      <= NOP_INST;
            inst_pc_q   <= RESET_PC;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = pc_q;
    assign inst_valid    = (state_q == ST_HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign fetch_err     = fetch_err_q;

    // Responses are only legal while one is owed.
    a_rsp_only_when_owed: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_valid |-> (state_q == ST_WAIT || state_q == ST_DROP));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        mem_rsp_err = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_fetch_err got=%b exp=0", fetch_err); end
        total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst got=%h exp=00000013", inst); end
        total++; if (inst_pc !== 32'h8000_0000) begin bad++; $display("FAIL reset_inst_pc got=%h exp=80000000", inst_pc); end
        rst_n = 1'b1;
        step();  // t1: IDLE -> REQ
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
            bad++; $display("FAIL first_req valid=%b addr=%h exp valid=1 addr=80000000", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_basic_fetch();
        mem_req_ready = 1'b1;
        step();  // t2: WAIT
        mem_req_ready = 1'b0;
        total++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL basic_wait req_valid=%b inst_valid=%b exp 0/0", mem_req_valid, inst_valid); end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0093;
        step();  // t3: HOLD
        mem_rsp_valid = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0000) begin
            bad++; $display("FAIL basic_hold valid=%b inst=%h pc=%h exp 1/00100093/80000000", inst_valid, inst, inst_pc); end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL basic_next req=%b addr=%h iv=%b exp 1/80000004/0", mem_req_valid, mem_req_addr, inst_valid); end
    endtask

    task automatic test_stall();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0040_0113;
        step();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (inst_valid !== 1'b1 || inst !== 32'h0040_0113 || inst_pc !== 32'h8000_0004 || mem_req_valid !== 1'b0) begin
                bad++; $display("FAIL stall_hold cyc=%0d iv=%b inst=%h pc=%h req=%b exp 1/00400113/80000004/0",
                                i, inst_valid, inst, inst_pc, mem_req_valid); end
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0008) begin
            bad++; $display("FAIL stall_next req=%b addr=%h exp 1/80000008", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        mem_req_ready = 1'b1;
        step();  // WAIT for 8000_0008
        mem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        step();  // DROP
        redirect_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL rw_drop req=%b iv=%b exp 0/0", mem_req_valid, inst_valid); end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        step();  // stale response discarded -> REQ
        mem_rsp_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL rw_next req=%b addr=%h iv=%b exp 1/80000100/0", mem_req_valid, mem_req_addr, inst_valid); end
        total++; if (inst === 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rw_stale inst=%h exp not deadbeef", inst); end
    endtask

    task automatic test_redirect_hold();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0033;
        step();
        mem_rsp_valid = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100) begin
            bad++; $display("FAIL rh_hold iv=%b pc=%h exp 1/80000100", inst_valid, inst_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; inst_ready = 1'b1;
        step();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0200 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL rh_next req=%b addr=%h iv=%b exp 1/80000200/0", mem_req_valid, mem_req_addr, inst_valid); end
    endtask

    task automatic test_fetch_err();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0008;
        step();  // redirect while REQ not yet accepted
        redirect_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0008) begin
            bad++; $display("FAIL err_req_redirect req=%b addr=%h exp 1/80000008", mem_req_valid, mem_req_addr); end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rsp_data = 32'h1234_5678;
        step();  // ERR
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        total++; if (fetch_err !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL err_enter ferr=%b req=%b iv=%b exp 1/0/0", fetch_err, mem_req_valid, inst_valid); end
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (fetch_err !== 1'b1 || mem_req_valid !== 1'b0) begin
                bad++; $display("FAIL err_sticky cyc=%0d ferr=%b req=%b exp 1/0", i, fetch_err, mem_req_valid); end
        end
        mem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        step();
        redirect_valid = 1'b0;
        total++; if (fetch_err !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
            bad++; $display("FAIL err_clear ferr=%b req=%b addr=%h exp 0/1/80000000", fetch_err, mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
        step();
        mem_rsp_valid = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_hold iv=%b pc=%h exp 1/fffffffc", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_next req=%b addr=%h exp 1/00000000", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_align();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100) begin
            bad++; $display("FAIL align req=%b addr=%h exp 1/80000100", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_req_redirect_drop();
        mem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        step();  // accepted with redirect -> DROP
        mem_req_ready = 1'b0; redirect_pc = 32'h8000_0400;
        total++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL drop_enter req=%b iv=%b exp 0/0", mem_req_valid, inst_valid); end
        step();  // redirect inside DROP, still owed a response
        redirect_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b0) begin
            bad++; $display("FAIL drop_stay req=%b exp 0", mem_req_valid); end
        mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0400 || fetch_err !== 1'b0) begin
            bad++; $display("FAIL drop_exit req=%b addr=%h ferr=%b exp 1/80000400/0", mem_req_valid, mem_req_addr, fetch_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = 32'h8000_0400;
        mem_req_ready = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();  // WAIT
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_1000 + i;
            step();  // HOLD
            mem_rsp_valid = 1'b0;
            total++; if (inst_valid !== 1'b1 || inst_pc !== base + 4 * i || inst !== 32'h0000_1000 + i) begin
                bad++; $display("FAIL b2b_hold i=%0d iv=%b pc=%h inst=%h exp 1/%h/%h",
                                i, inst_valid, inst_pc, inst, base + 4 * i, 32'h0000_1000 + i); end
            step();  // REQ, three cycles after the previous REQ
            total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== base + 4 * (i + 1)) begin
                bad++; $display("FAIL b2b_req i=%0d req=%b addr=%h exp 1/%h", i, mem_req_valid, mem_req_addr, base + 4 * (i + 1)); end
        end
        mem_req_ready = 1'b0; inst_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_req_ready = 1'b1;
        step();  // WAIT
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        total++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000) begin
            bad++; $display("FAIL rstmid req=%b iv=%b inst=%h pc=%h exp 0/0/00000013/80000000", mem_req_valid, inst_valid, inst, inst_pc); end
        rst_n = 1'b1;
        step();
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
            bad++; $display("FAIL rstmid_req req=%b addr=%h exp 1/80000000", mem_req_valid, mem_req_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_fetch_err();
        test_wrap();
        test_align();
        test_req_redirect_drop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
